// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports with bypass,
// and a hardware clear sequencer that zeroes every entry after reset or on request.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     rdy,
  output logic                     wr_collide
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic wr_open_c;
  logic wr0_c;
  logic wr1_c;
  logic collide_c;

  // Entry 0 is writable/readable only when it is not hardwired to zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign wr_open_c = (state == READY) && !clr_req && !rst;
  assign wr0_c     = wr_open_c && we0 && addr_ok(waddr0);
  assign wr1_c     = wr_open_c && we1 && addr_ok(waddr1);
  assign collide_c = we0 && we1 && (waddr0 == waddr1) && addr_ok(waddr0);
  assign rdy       = (state == READY);

  // Sequencer, array update and collision flag; the array is untouched by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      wr_collide <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[cnt[ADDR_W-1:0]] <= '0;
          cnt                   <= cnt + CNT_W'(1);
          wr_collide            <= 1'b0;
          if (cnt == CNT_W'(DEPTH - 1)) begin
            state <= READY;
          end
        end
        READY: begin
          if (clr_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            wr_collide <= 1'b0;
          end else begin
            // Port 1 wins a same-address collision.
            if (wr0_c && !(wr1_c && (waddr0 == waddr1))) begin
              regs[waddr0] <= wdata0;
            end
            if (wr1_c) begin
              regs[waddr1] <= wdata1;
            end
            wr_collide <= collide_c;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Zero-latency reads with write-to-read bypass, port 1 ahead of port 0.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      logic [ADDR_W-1:0] a;
      a = raddr[i*ADDR_W +: ADDR_W];
      if (rst || (state != READY) || !re[i] || !addr_ok(a)) begin
        rdata[i*DATA_W +: DATA_W] = '0;
      end else if (wr1_c && (waddr1 == a)) begin
        rdata[i*DATA_W +: DATA_W] = wdata1;
      end else if (wr0_c && (waddr0 == a)) begin
        rdata[i*DATA_W +: DATA_W] = wdata0;
      end else begin
        rdata[i*DATA_W +: DATA_W] = regs[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the register file.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 32;

  logic           clk;
  logic           rst;
  logic           clr_req;
  logic           we0;
  logic [AW-1:0]  waddr0;
  logic [DW-1:0]  wdata0;
  logic           we1;
  logic [AW-1:0]  waddr1;
  logic [DW-1:0]  wdata1;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic           rdy;
  logic           wr_collide;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .rdy(rdy), .wr_collide(wr_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: contents, busy flag with remaining clear edges, collision flag.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_valid = 1'b0;
  bit            m_busy  = 1'b1;
  int            m_left  = 0;
  bit            m_coll  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] a;
    a = raddr[i*AW +: AW];
    if (rst || m_busy || !re[i] || a == 0) return '0;
    if (!clr_req) begin
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
    end
    return m_regs[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b1;
      m_left  = DEPTH;
      m_coll  = 1'b0;
    end else if (m_valid) begin
      if (m_busy) begin
        m_left--;
        m_coll = 1'b0;
        if (m_left == 0) begin
          m_busy = 1'b0;
          for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
        end
      end else if (clr_req) begin
        m_busy = 1'b1;
        m_left = DEPTH;
        m_coll = 1'b0;
      end else begin
        if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
        if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
        m_coll = we0 && we1 && (waddr0 == waddr1) && (waddr0 != 0);
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("rdy", 64'(rdy), 64'(!m_busy));
      chk("wr_collide", 64'(wr_collide), 64'(m_coll));
    end
    if (m_valid || rst) begin
      for (int i = 0; i < NR; i++)
        chk($sformatf("rdata%0d", i), 64'(rdata[i*DW +: DW]), 64'(exp_rd(i)));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; clr_req = 0; we0 = 0; we1 = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = '0; raddr = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    re = 2'b11;
    raddr = {a1, a0};
  endtask

  // Count edges until rdy rises; optionally pulse clr_req at a given edge count.
  task automatic wait_rdy(input int pulse_at, output int n);
    n = 0;
    while (!rdy && n < 100) begin
      clr_req = (n == pulse_at);
      tick();
      n++;
    end
    clr_req = 0;
  endtask

  int n;

  initial begin
    idle();
    rst = 1;

    // 1: reset, clear, write during clear is lost
    tick(); tick();
    rst = 0;
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hDEAD;
    tick();
    idle();
    n = 1;
    while (!rdy && n < 100) begin tick(); n++; end
    chk("clr_len_reset", 64'(n), 64'd32);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd(5'(a), 5'(a + 1));
      #1;
      chk("clr_zero", 64'(rdata), 64'd0);
      tick();
    end
    rd(5'd3, 5'd3); #1;
    chk("reg3_lost", 64'(rdata[31:0]), 64'd0);
    tick();

    // 2: zero register
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0); #1;
    chk("zero_same", 64'(rdata), 64'd0);
    tick();
    we0 = 0; we1 = 0; #1;
    chk("zero_after", 64'(rdata), 64'd0);
    chk("zero_nocoll", 64'(wr_collide), 64'd0);
    tick();

    // 3: bypass and port-1 priority
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1111;
    we1 = 1; waddr1 = 5'd5; wdata1 = 32'h2222;
    rd(5'd5, 5'd5); #1;
    chk("byp_p0", 64'(rdata[31:0]), 64'h2222);
    chk("byp_p1", 64'(rdata[63:32]), 64'h2222);
    tick();
    we0 = 0; we1 = 0; #1;
    chk("reg5", 64'(rdata[31:0]), 64'h2222);
    chk("coll_set", 64'(wr_collide), 64'd1);
    tick();
    chk("coll_clr", 64'(wr_collide), 64'd0);

    // 4: independent dual write, read-enable gating
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'hA5A5_0007;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h5A5A_0009;
    re = 0;
    tick();
    we0 = 0; we1 = 0;
    rd(5'd7, 5'd9); #1;
    chk("dual_p0", 64'(rdata[31:0]), 64'hA5A5_0007);
    chk("dual_p1", 64'(rdata[63:32]), 64'h5A5A_0009);
    re = 2'b10; #1;
    chk("re_off", 64'(rdata[31:0]), 64'd0);
    tick();

    // 5: soft clear with a second pulse mid-sequence
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'h44;
    we1 = 1; waddr1 = 5'd31; wdata1 = 32'h31;
    tick();
    idle();
    clr_req = 1; we0 = 1; waddr0 = 5'd6; wdata0 = 32'h66;
    rd(5'd6, 5'd4); #1;
    chk("clr_nobyp", 64'(rdata[31:0]), 64'd0);
    chk("clr_stored", 64'(rdata[63:32]), 64'h44);
    tick();
    idle();
    wait_rdy(10, n);
    chk("clr_len_soft", 64'(n), 64'd32);
    rd(5'd4, 5'd6); #1;
    chk("soft_r4_r6", 64'(rdata), 64'd0);
    tick();
    rd(5'd31, 5'd31); #1;
    chk("soft_r31", 64'(rdata), 64'd0);
    tick();

    // 6: reset in the middle of a clear
    idle();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 9; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_rdy(-1, n);
    chk("clr_len_midrst", 64'(n), 64'd32);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clr_req = ($urandom_range(0, 63) == 0);
      we0     = 1'($urandom);
      we1     = 1'($urandom);
      waddr0  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      waddr1  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wdata0  = $urandom;
      wdata1  = $urandom;
      re      = 2'($urandom);
      raddr   = {($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                 ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom)};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
